// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the matching transmitter:
// parity-mode constants, receiver state encoding and the parity rule.
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_ARM, ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } rx_state_e;

   // Line value the parity bit must carry, given the XOR of the data bits.
   function automatic logic parity_expect(input int mode, input logic data_xor);
      return (mode == PAR_ODD) ? ~data_xor : data_xor;
   endfunction
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input, with a selectable reset value
// so an idle-high serial line does not look like a start bit out of reset.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);
   logic meta_q, sync_q;

   // NOTE: flops are written with <= so every stage samples its input from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling off a clock-count bit timer,
// optional parity, 1 or 2 stop bits, one-word output register with valid/ready.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PAR_EVEN,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FLUSH = CNT_W'(2);
   localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [3:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q, data_q;
   logic                 par_flag_q, frm_flag_q;
   logic                 valid_q, perr_q, ferr_q, ovr_q, busy_q;
   logic                 tick, accept, frm_flag_d, par_flag_d;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk(clk),
      .rst(rst),
      .d_i(rx_in),
      .q_o(rx_s)
   );

   assign tick       = (cnt_q == '0);
   assign accept     = valid_q & rx_ready;
   assign frm_flag_d = frm_flag_q | ~rx_s;
   assign par_flag_d = (rx_s != parity_expect(PARITY, ^shift_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_ARM;
         cnt_q      <= CNT_FLUSH;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_flag_q <= 1'b0;
         frm_flag_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         cnt_q <= tick ? CNT_FULL : cnt_q - 1'b1;
         if (accept) valid_q <= 1'b0;

         unique case (state_q)
            // The synchronizer still holds its reset value for two cycles;
            // only a line value that really came from the pin may arm us.
            ST_ARM: begin
               cnt_q <= tick ? '0 : cnt_q - 1'b1;
               if (tick && rx_s) state_q <= ST_IDLE;
            end
            ST_IDLE: begin
               cnt_q <= CNT_HALF;
               if (!rx_s) begin
                  state_q <= ST_START;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: if (tick) begin
               if (rx_s) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q    <= ST_DATA;
                  bit_cnt_q  <= '0;
                  par_flag_q <= 1'b0;
                  frm_flag_q <= 1'b0;
               end
            end
            ST_DATA: if (tick) begin
               shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_q <= '0;
                  state_q   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            ST_PARITY: if (tick) begin
               par_flag_q <= par_flag_d;
               state_q    <= ST_STOP;
            end
            ST_STOP: if (tick) begin
               frm_flag_q <= frm_flag_d;
               bit_cnt_q  <= bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_STOP) begin
                  state_q <= rx_s ? ST_IDLE : ST_BREAK;
                  busy_q  <= ~rx_s;
                  if (!valid_q || rx_ready) begin
                     data_q  <= shift_q;
                     perr_q  <= par_flag_q;
                     ferr_q  <= frm_flag_d;
                     valid_q <= 1'b1;
                  end else begin
                     ovr_q <= 1'b1;
                  end
               end
            end
            ST_BREAK: if (rx_s) begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_ARM;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data    = data_q;
   assign rx_valid   = valid_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overrun    = ovr_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three parameter sets driven by a frame builder and
// checked against expectations derived from the frame format and timing rules.
module tb_uart_rx_param;
   import uart_pkg::*;

   localparam int NDUT = 3;

   // Instance 0: 16/8/even/1, instance 1: 5/8/odd/1, instance 2: 4/7/none/2.
   function automatic int cpb(input int d);
      return (d == 0) ? 16 : (d == 1) ? 5 : 4;
   endfunction
   function automatic int dbits(input int d);
      return (d == 2) ? 7 : 8;
   endfunction
   function automatic int par(input int d);
      return (d == 0) ? PAR_EVEN : (d == 1) ? PAR_ODD : PAR_NONE;
   endfunction
   function automatic int stops(input int d);
      return (d == 2) ? 2 : 1;
   endfunction
   function automatic int fbits(input int d);
      return 1 + dbits(d) + ((par(d) != PAR_NONE) ? 1 : 0) + stops(d);
   endfunction
   function automatic int lat(input int d);
      return 2 + cpb(d) / 2 + (fbits(d) - 1) * cpb(d) + 1;
   endfunction

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NDUT-1:0] line = '1;
   logic [NDUT-1:0] rdy = '0;
   logic [7:0]      data_a, data_b;
   logic [6:0]      data_c;
   logic            valid_a, valid_b, valid_c, perr_a, perr_b, perr_c;
   logic            ferr_a, ferr_b, ferr_c, ovr_a, ovr_b, ovr_c, busy_a, busy_b, busy_c;
   logic [NDUT-1:0] valid, perr, ferr, ovr, busy;
   logic [8:0]      data_m [NDUT];

   always #5 clk = ~clk;

   uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .rx_in(line[0]), .rx_data(data_a), .rx_valid(valid_a),
      .rx_ready(rdy[0]), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));
   uart_rx_param #(.CLKS_PER_BIT(5), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) dut_b (
      .clk(clk), .rst(rst), .rx_in(line[1]), .rx_data(data_b), .rx_valid(valid_b),
      .rx_ready(rdy[1]), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));
   uart_rx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_c (
      .clk(clk), .rst(rst), .rx_in(line[2]), .rx_data(data_c), .rx_valid(valid_c),
      .rx_ready(rdy[2]), .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c), .busy(busy_c));

   assign valid = {valid_c, valid_b, valid_a};
   assign perr  = {perr_c, perr_b, perr_a};
   assign ferr  = {ferr_c, ferr_b, ferr_a};
   assign ovr   = {ovr_c, ovr_b, ovr_a};
   assign busy  = {busy_c, busy_b, busy_a};
   always_comb begin
      data_m[0] = 9'(data_a);
      data_m[1] = 9'(data_b);
      data_m[2] = 9'(data_c);
   end

   // Observer: records accepted words, rx_valid rising edges and overrun pulses.
   typedef struct {
      int         d;
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } rec_t;

   rec_t            got_q[$];
   int              cyc = 0;
   logic [NDUT-1:0] valid_prev = '0;
   int              rise_cnt [NDUT] = '{default: 0};
   int              rise_cyc [NDUT] = '{default: 0};
   int              ovr_cnt  [NDUT] = '{default: 0};
   int              ovr_cyc  [NDUT] = '{default: 0};

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      valid_prev <= valid;
      for (int d = 0; d < NDUT; d++) begin
         if (valid[d] === 1'b1 && valid_prev[d] !== 1'b1) begin
            rise_cnt[d] <= rise_cnt[d] + 1;
            rise_cyc[d] <= cyc;
         end
         if (ovr[d] === 1'b1) begin
            ovr_cnt[d] <= ovr_cnt[d] + 1;
            ovr_cyc[d] <= cyc;
         end
         if (valid[d] === 1'b1 && rdy[d] === 1'b1)
            got_q.push_back(rec_t'{d, data_m[d], perr[d], ferr[d]});
      end
   end

   int checks = 0;
   int errors = 0;
   int rd_ptr = 0;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame on instance d starting at the current negedge; t0 is the
   // cycle of the start-bit falling edge, stop_len the length of the last bit.
   task automatic send_frame(input int d, input logic [8:0] data, input logic bad_par,
                             input logic [1:0] stop_v, input int stop_len, output int t0);
      logic [15:0] bits;
      logic        p;
      int          n;
      bits = '1;
      n    = 0;
      bits[n] = 1'b0;
      n++;
      p = 1'b0;
      for (int i = 0; i < dbits(d); i++) begin
         bits[n] = data[i];
         p       = p ^ data[i];
         n++;
      end
      if (par(d) != PAR_NONE) begin
         bits[n] = ((par(d) == PAR_ODD) ? ~p : p) ^ bad_par;
         n++;
      end
      for (int i = 0; i < stops(d); i++) begin
         bits[n] = stop_v[i];
         n++;
      end
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         line[d] = bits[i];
         wait_cyc((i == n - 1) ? stop_len : cpb(d));
      end
   endtask

   // Accepts the next word from instance d and compares it with the expectation.
   task automatic expect_word(input int d, input logic [8:0] w, input logic pe, input logic fe,
                              input int t0, input string name);
      rec_t r;
      bit   found;
      found  = 1'b0;
      rdy[d] = 1'b1;
      for (int i = 0; i < 4 * fbits(d) * cpb(d) + 50 && !found; i++) begin
         @(negedge clk);
         if (got_q.size() > rd_ptr) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s: no word delivered by instance %0d within the cycle budget", name, d);
      end else begin
         r = got_q[rd_ptr];
         rd_ptr++;
         checks++;
         if (r.d !== d || r.data !== w) begin
            errors++;
            $display("FAIL %s data: got inst %0d 0x%h, want inst %0d 0x%h", name, r.d, r.data, d, w);
         end
         checks++;
         if (r.perr !== pe) begin
            errors++;
            $display("FAIL %s parity_err: got %b, want %b", name, r.perr, pe);
         end
         checks++;
         if (r.ferr !== fe) begin
            errors++;
            $display("FAIL %s frame_err: got %b, want %b", name, r.ferr, fe);
         end
         if (t0 >= 0) begin
            checks++;
            if (rise_cyc[d] - t0 !== lat(d)) begin
               errors++;
               $display("FAIL %s latency: got %0d cycles, want %0d", name, rise_cyc[d] - t0, lat(d));
            end
         end
         checks++;
         if (valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_fall: rx_valid got %b after acceptance, want 0", name, valid[d]);
         end
      end
      rdy[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      line = '1;
      rdy  = '0;
      wait_cyc(4);
      for (int d = 0; d < NDUT; d++) begin
         checks++;
         if ({valid[d], perr[d], ferr[d], ovr[d], busy[d]} !== 5'b0 || data_m[d] !== 9'h0) begin
            errors++;
            $display("FAIL reset inst %0d: v/pe/fe/ov/busy=%b data=0x%h, want all 0",
                     d, {valid[d], perr[d], ferr[d], ovr[d], busy[d]}, data_m[d]);
         end
      end
      rst = 1'b0;
      wait_cyc(6);
      checks++;
      if (valid !== '0 || busy !== '0) begin
         errors++;
         $display("FAIL reset_release: valid=%b busy=%b, want 000/000", valid, busy);
      end
   endtask

   task automatic test_basic();
      int t0;
      send_frame(0, 9'h0A5, 1'b0, 2'b11, cpb(0), t0);
      checks++;
      if (rise_cyc[0] - t0 !== 171) begin
         errors++;
         $display("FAIL basic_latency: got %0d cycles, want 171", rise_cyc[0] - t0);
      end
      expect_word(0, 9'h0A5, 1'b0, 1'b0, t0, "basic_a5");
   endtask

   task automatic test_parity();
      int t0;
      send_frame(0, 9'h0A5, 1'b1, 2'b11, cpb(0), t0);
      expect_word(0, 9'h0A5, 1'b1, 1'b0, t0, "even_bad_parity");
      send_frame(1, 9'h0A5, 1'b0, 2'b11, cpb(1), t0);
      line[1] = 1'b1;
      expect_word(1, 9'h0A5, 1'b0, 1'b0, t0, "odd_parity_ok");
      send_frame(1, 9'h0A5, 1'b1, 2'b11, cpb(1), t0);
      line[1] = 1'b1;
      expect_word(1, 9'h0A5, 1'b1, 1'b0, t0, "odd_bad_parity");
   endtask

   task automatic test_frame_break();
      int t0, rc;
      send_frame(0, 9'h03C, 1'b0, 2'b10, cpb(0), t0);
      expect_word(0, 9'h03C, 1'b0, 1'b1, t0, "frame_err");
      rc = rise_cnt[0];
      wait_cyc(3 * cpb(0));
      checks++;
      if (busy[0] !== 1'b1 || rise_cnt[0] !== rc) begin
         errors++;
         $display("FAIL break_hold: busy=%b new frames=%0d, want busy 1 and 0 frames", busy[0], rise_cnt[0] - rc);
      end
      line[0] = 1'b1;
      wait_cyc(2 * cpb(0));
      checks++;
      if (busy[0] !== 1'b0 || rise_cnt[0] !== rc) begin
         errors++;
         $display("FAIL break_exit: busy=%b new frames=%0d, want busy 0 and 0 frames", busy[0], rise_cnt[0] - rc);
      end
   endtask

   task automatic test_glitch();
      int rc;
      rc      = rise_cnt[0];
      line[0] = 1'b0;
      wait_cyc(5);
      line[0] = 1'b1;
      checks++;
      if (busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL glitch_start: busy got %b during the low pulse, want 1", busy[0]);
      end
      wait_cyc(2 * cpb(0));
      checks++;
      if (busy[0] !== 1'b0 || valid[0] !== 1'b0 || rise_cnt[0] !== rc) begin
         errors++;
         $display("FAIL glitch_reject: busy=%b valid=%b frames=%0d, want 0/0/0", busy[0], valid[0], rise_cnt[0] - rc);
      end
   endtask

   task automatic test_overrun();
      int t1, t2, oc;
      oc     = ovr_cnt[0];
      rdy[0] = 1'b0;
      send_frame(0, 9'h011, 1'b0, 2'b11, cpb(0), t1);
      wait_cyc(cpb(0));
      send_frame(0, 9'h022, 1'b0, 2'b11, cpb(0), t2);
      wait_cyc(4);
      checks++;
      if (valid[0] !== 1'b1 || data_m[0] !== 9'h011) begin
         errors++;
         $display("FAIL overrun_hold: valid=%b data=0x%h, want 1 and 0x011", valid[0], data_m[0]);
      end
      checks++;
      if (ovr_cnt[0] - oc !== 1) begin
         errors++;
         $display("FAIL overrun_pulses: got %0d cycles of overrun, want 1", ovr_cnt[0] - oc);
      end
      checks++;
      if (ovr_cyc[0] - t2 !== lat(0)) begin
         errors++;
         $display("FAIL overrun_timing: got %0d cycles after start, want %0d", ovr_cyc[0] - t2, lat(0));
      end
      expect_word(0, 9'h011, 1'b0, 1'b0, -1, "overrun_accept");
   endtask

   task automatic test_back_to_back();
      int ta, tb;
      rdy[0] = 1'b1;
      send_frame(0, 9'h03C, 1'b0, 2'b11, cpb(0) / 2 + 1, ta);
      send_frame(0, 9'h0C3, 1'b0, 2'b11, cpb(0), tb);
      expect_word(0, 9'h03C, 1'b0, 1'b0, -1, "b2b_first");
      expect_word(0, 9'h0C3, 1'b0, 1'b0, tb, "b2b_second");
   endtask

   task automatic test_reset_mid();
      int t0, rc;
      send_frame(0, 9'h05A, 1'b0, 2'b11, cpb(0), t0);
      line[0] = 1'b0;
      wait_cyc(4 * cpb(0) + 3);
      checks++;
      if (busy[0] !== 1'b1 || valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: busy=%b valid=%b, want 1/1", busy[0], valid[0]);
      end
      rst = 1'b1;
      wait_cyc(1);
      checks++;
      if ({valid[0], perr[0], ferr[0], ovr[0], busy[0]} !== 5'b0 || data_m[0] !== 9'h0) begin
         errors++;
         $display("FAIL rst_mid: v/pe/fe/ov/busy=%b data=0x%h, want all 0",
                  {valid[0], perr[0], ferr[0], ovr[0], busy[0]}, data_m[0]);
      end
      wait_cyc(1);
      rst = 1'b0;
      rc  = rise_cnt[0];
      wait_cyc((fbits(0) + 1) * cpb(0));
      checks++;
      if (busy[0] !== 1'b0 || valid[0] !== 1'b0 || rise_cnt[0] !== rc) begin
         errors++;
         $display("FAIL rst_arm: busy=%b valid=%b frames=%0d with line low, want 0/0/0", busy[0], valid[0], rise_cnt[0] - rc);
      end
      line[0] = 1'b1;
      wait_cyc(cpb(0));
      send_frame(0, 9'h096, 1'b0, 2'b11, cpb(0), t0);
      expect_word(0, 9'h096, 1'b0, 1'b0, t0, "rst_recover");
   endtask

   task automatic test_seven_two();
      int t0;
      send_frame(2, 9'h055, 1'b0, 2'b11, cpb(2), t0);
      expect_word(2, 9'h055, 1'b0, 1'b0, t0, "c_0x55");
      send_frame(2, 9'h02A, 1'b0, 2'b01, cpb(2), t0);
      line[2] = 1'b1;
      expect_word(2, 9'h02A, 1'b0, 1'b1, t0, "c_second_stop_low");
   endtask

   task automatic test_random();
      int         t0;
      logic [8:0] w;
      logic       bp, fe;
      logic [1:0] sv;
      for (int d = 0; d < NDUT; d++) begin
         for (int k = 0; k < 8; k++) begin
            w  = 9'($urandom) & 9'((1 << dbits(d)) - 1);
            bp = (par(d) != PAR_NONE) && ($urandom_range(3) == 0);
            sv = 2'b11;
            if ($urandom_range(3) == 0) sv[$urandom_range(stops(d) - 1)] = 1'b0;
            fe = 1'b0;
            for (int s = 0; s < stops(d); s++) if (!sv[s]) fe = 1'b1;
            send_frame(d, w, bp, sv, cpb(d), t0);
            line[d] = 1'b1;
            expect_word(d, w, bp, fe, t0, $sformatf("rand_i%0d_f%0d", d, k));
            wait_cyc(cpb(d) + $urandom_range(cpb(d)));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_basic();
      wait_cyc(cpb(0));
      test_parity();
      wait_cyc(cpb(0));
      test_frame_break();
      test_glitch();
      test_overrun();
      wait_cyc(cpb(0));
      test_back_to_back();
      wait_cyc(cpb(0));
      test_reset_mid();
      wait_cyc(cpb(0));
      test_seven_two();
      wait_cyc(cpb(0));
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
